// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: decoder FSM states, default polynomial, and the
// forward/reverse step functions used by both the encoder and the decoder.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam int         LFSR_W    = 8;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h01;

    // Functions work on a fixed container width so any W up to MAX_W can share them.
    localparam int MAX_W = 32;

    // next = {s[w-2:0], ^(s & taps)}
    function automatic logic [MAX_W-1:0] lfsr_fwd(input logic [MAX_W-1:0] s,
                                                  input logic [MAX_W-1:0] taps,
                                                  input int               w);
        logic [MAX_W-1:0] n;
        logic             fb;
        n  = '0;
        fb = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) fb = fb ^ (s[i] & taps[i]);
        end
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) n[i] = (i == 0) ? fb : s[i-1];
        end
        return n;
    endfunction

    // Exact inverse of lfsr_fwd; requires taps[w-1] set.
    function automatic logic [MAX_W-1:0] lfsr_rev(input logic [MAX_W-1:0] n,
                                                  input logic [MAX_W-1:0] taps,
                                                  input int               w);
        logic [MAX_W-1:0] p;
        logic             fb;
        p  = '0;
        fb = n[0];
        for (int i = 1; i < MAX_W; i++) begin
            if (i < w) begin
                p[i-1] = n[i];
                fb     = fb ^ (n[i] & taps[i-1]);
            end
        end
        p[w-1] = fb;
        return p;
    endfunction

endpackage

// File: rtl/lfsr_rev_step.sv
// Combinational single reverse step of a W-bit Fibonacci LFSR.
module lfsr_rev_step
    import lfsr_pkg::*;
#(
    parameter int           W    = LFSR_W,
    parameter logic [W-1:0] TAPS = LFSR_TAPS
) (
    input  logic [W-1:0] cur,
    output logic [W-1:0] prev
);

    logic [MAX_W-1:0] full;
    logic             unused_bits;

    assign full        = lfsr_rev(MAX_W'(cur), MAX_W'(TAPS), W);
    assign prev        = full[W-1:0];
    assign unused_bits = ^full;

endmodule

// File: rtl/lfsr_count_decoder.sv
// Converts an LFSR counter state into its binary step count from SEED by
// walking the LFSR backwards one step per clock.
module lfsr_count_decoder
    import lfsr_pkg::*;
#(
    parameter int           W    = LFSR_W,
    parameter logic [W-1:0] TAPS = LFSR_TAPS,
    parameter logic [W-1:0] SEED = LFSR_SEED
) (
    input  logic         CLK,
    input  logic         rstb,
    input  logic         start,
    input  logic [W-1:0] state_in,
    output logic         ready,
    output logic         done,
    output logic         err,
    output logic [W-1:0] count
);

    // Largest legal count (2^W-2); reaching it without hitting SEED means a non-maximal polynomial.
    localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

    fsm_t         state;
    logic [W-1:0] cur;
    logic [W-1:0] cnt;
    logic [W-1:0] prev;

    lfsr_rev_step #(
        .W    (W),
        .TAPS (TAPS)
    ) u_rev (
        .cur  (cur),
        .prev (prev)
    );

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge CLK) begin
        if (rstb) begin
            state <= IDLE;
            cur   <= '0;
            cnt   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur   <= state_in;
                        cnt   <= '0;
                        err   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cur == SEED) begin
                        count <= cnt;
                        err   <= 1'b0;
                        state <= DONE;
                    end else if (cur == '0) begin
                        count <= '0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        count <= '0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cur <= prev;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_count_decoder.sv
// Directed bench for lfsr_count_decoder (W=8, TAPS=8'hB8, SEED=8'h01).
module tb_lfsr_count_decoder;

    logic       CLK = 1'b0;
    logic       rstb;
    logic       start;
    logic [7:0] state_in;
    logic       ready;
    logic       done;
    logic       err;
    logic [7:0] count;

    int passed = 0;
    int total  = 0;

    lfsr_count_decoder #(
        .W    (8),
        .TAPS (8'hB8),
        .SEED (8'h01)
    ) dut (
        .CLK      (CLK),
        .rstb     (rstb),
        .start    (start),
        .state_in (state_in),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] stim;
        logic [7:0] exp_count;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    // Reference: index of every state along the forward sequence from SEED.
    int   idx  [256];
    bit   valid[256];
    int   expq [$];
    logic [7:0] inq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Presents one start while ready=1; returns cycles until done (from the accepting cycle).
    task automatic decode(input logic [7:0] s, input int budget, output int lat, output logic busy_ok);
        state_in = s;
        start    = 1'b1;
        lat      = 0;
        busy_ok  = 1'b1;
        do begin
            @(posedge CLK); #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (ready) busy_ok = 1'b0;
        end while (!done && lat < budget);
    endtask

    task automatic handle_done();
        logic [7:0] s;
        if (done) begin
            chk("spurious_done", expq.size(), 1);
            if (expq.size() > 0) begin
                s = inq.pop_front();
                void'(expq.pop_front());
                if (valid[s]) begin
                    chk($sformatf("held_count_%02h", s), count, idx[s]);
                    chk($sformatf("held_err_%02h", s), err, 0);
                end else begin
                    chk($sformatf("held_count_%02h", s), count, 0);
                    chk($sformatf("held_err_%02h", s), err, 1);
                end
            end
        end
    endtask

    initial begin
        int         lat;
        logic       busy_ok;
        logic [7:0] s;
        logic       fb;
        int         accepts;
        int         pulses;
        logic       saw_done;

        vecs[0] = '{stim: 8'h01, exp_count: 8'd0,   exp_err: 1'b0, exp_lat: 2};
        vecs[1] = '{stim: 8'h11, exp_count: 8'd4,   exp_err: 1'b0, exp_lat: 6};
        vecs[2] = '{stim: 8'h23, exp_count: 8'd5,   exp_err: 1'b0, exp_lat: 7};
        vecs[3] = '{stim: 8'h80, exp_count: 8'd254, exp_err: 1'b0, exp_lat: 256};
        vecs[4] = '{stim: 8'h00, exp_count: 8'd0,   exp_err: 1'b1, exp_lat: 2};
        vecs[5] = '{stim: 8'h04, exp_count: 8'd2,   exp_err: 1'b0, exp_lat: 4};

        for (int i = 0; i < 256; i++) begin
            idx[i]   = 0;
            valid[i] = 1'b0;
        end
        s = 8'h01;
        for (int k = 0; k < 255; k++) begin
            idx[s]   = k;
            valid[s] = 1'b1;
            fb       = ^(s & 8'hB8);
            s        = {s[6:0], fb};
        end

        rstb     = 1'b1;
        start    = 1'b0;
        state_in = 8'h00;
        repeat (2) @(posedge CLK);
        #1 rstb = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_done",  done,  0);
        chk("rst_err",   err,   0);
        chk("rst_count", count, 0);

        for (int i = 0; i < 6; i++) begin
            decode(vecs[i].stim, 400, lat, busy_ok);
            chk($sformatf("done_seen_%02h", vecs[i].stim), done, 1);
            chk($sformatf("latency_%02h", vecs[i].stim), lat, vecs[i].exp_lat);
            chk($sformatf("count_%02h", vecs[i].stim), count, vecs[i].exp_count);
            chk($sformatf("err_%02h", vecs[i].stim), err, vecs[i].exp_err);
            chk($sformatf("busy_%02h", vecs[i].stim), busy_ok, 1);
            @(posedge CLK); #1;
            chk($sformatf("done_pulse_%02h", vecs[i].stim), done, 0);
            chk($sformatf("ready_back_%02h", vecs[i].stim), ready, 1);
            chk($sformatf("count_hold_%02h", vecs[i].stim), count, vecs[i].exp_count);
        end

        // Reset in the middle of a long decode must abort it silently.
        state_in = 8'h80;
        start    = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (48) @(posedge CLK);
        #1 rstb = 1'b1;
        @(posedge CLK); #1;
        rstb = 1'b0;
        chk("abort_ready", ready, 1);
        chk("abort_done",  done,  0);
        saw_done = 1'b0;
        repeat (300) begin
            @(posedge CLK); #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        decode(8'h02, 400, lat, busy_ok);
        chk("post_abort_lat",   lat,   3);
        chk("post_abort_count", count, 1);
        chk("post_abort_err",   err,   0);
        @(posedge CLK); #1;

        // start held high with a new state_in every cycle: only idle-cycle values are taken.
        accepts = 0;
        pulses  = 0;
        start   = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            state_in = 8'($urandom_range(0, 255));
            if (ready) begin
                inq.push_back(state_in);
                expq.push_back(1);
                accepts++;
            end
            @(posedge CLK); #1;
            if (done) pulses++;
            handle_done();
        end
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && expq.size() > 0; cyc++) begin
            @(posedge CLK); #1;
            if (done) pulses++;
            handle_done();
        end
        chk("held_queue_empty", expq.size(), 0);
        chk("held_pulses", pulses, accepts);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
